// File: rtl/jelly_rtos_semaphore_array_if.sv
// Operation and response bundle between the RTOS kernel and the semaphore bank.
//
// Handshake: every *_valid input is a single-cycle request with no ready.
// The bank accepts one op on each rising edge with cke=1. The op is chosen by
// fixed priority: sig > pol > wai > rel. Lower-priority requests in the same
// cycle are dropped. Responses (wakeup_valid, pol_sem_ack, rel_wai_ack,
// op_err) are registered and last exactly one cycle after the accepting edge.
interface jelly_rtos_semaphore_array_if #(
  parameter int SEM_NUM      = 4,
  parameter int SEMID_WIDTH  = 2,
  parameter int SEMCNT_WIDTH = 4,
  parameter int QUECNT_WIDTH = 4,
  parameter int TSKID_WIDTH  = 4,
  parameter int TSKPRI_WIDTH = 4
);
  logic [SEMID_WIDTH-1:0]          op_semid;
  logic [TSKID_WIDTH-1:0]          op_tskid;
  logic [TSKPRI_WIDTH-1:0]         op_tskpri;
  logic                            sig_sem_valid;
  logic                            pol_sem_valid;
  logic                            wai_sem_valid;
  logic                            rel_wai_valid;
  logic [TSKID_WIDTH-1:0]          wakeup_tskid;
  logic                            wakeup_valid;
  logic                            pol_sem_ack;
  logic                            rel_wai_ack;
  logic                            op_err;
  logic [SEM_NUM*SEMCNT_WIDTH-1:0] semcnt;
  logic [QUECNT_WIDTH-1:0]         quecnt;

  modport master (
    output op_semid, op_tskid, op_tskpri,
    output sig_sem_valid, pol_sem_valid, wai_sem_valid, rel_wai_valid,
    input  wakeup_tskid, wakeup_valid, pol_sem_ack, rel_wai_ack, op_err,
    input  semcnt, quecnt
  );

  modport slave (
    input  op_semid, op_tskid, op_tskpri,
    input  sig_sem_valid, pol_sem_valid, wai_sem_valid, rel_wai_valid,
    output wakeup_tskid, wakeup_valid, pol_sem_ack, rel_wai_ack, op_err,
    output semcnt, quecnt
  );
endinterface

// File: rtl/jelly_rtos_semaphore_array.sv
// Bank of SEM_NUM saturating counting semaphores sharing one ordered wait
// queue (oldest entry at index 0).
// Optional macro JELLY_RTOS_SEMAPHORE_ARRAY_PRIORITY_EN: sig_sem wakes the
// waiter with the lowest tskpri value, oldest first on ties. Without the
// macro, each semaphore wakes its waiters in FIFO order.
module jelly_rtos_semaphore_array #(
  parameter int SEM_NUM      = 4,
  parameter int SEMID_WIDTH  = 2,
  parameter int SEMCNT_WIDTH = 4,
  parameter int MAX_SEMCNT   = 15,
  parameter int INIT_SEMCNT  = 0,
  parameter int QUE_SIZE     = 8,
  parameter int QUECNT_WIDTH = $clog2(QUE_SIZE + 1),
  parameter int TSKID_WIDTH  = 4,
  parameter int TSKPRI_WIDTH = 4
) (
  input  logic                         reset,
  input  logic                         clk,
  input  logic                         cke,
  jelly_rtos_semaphore_array_if.slave  bus
);

  localparam int QIDX_WIDTH = (QUE_SIZE > 1) ? $clog2(QUE_SIZE) : 1;

  logic [SEMCNT_WIDTH-1:0] cnt_q       [SEM_NUM];
  logic [SEMCNT_WIDTH-1:0] cnt_d       [SEM_NUM];
  logic [TSKID_WIDTH-1:0]  que_tskid_q [QUE_SIZE];
  logic [TSKID_WIDTH-1:0]  que_tskid_d [QUE_SIZE];
  logic [SEMID_WIDTH-1:0]  que_semid_q [QUE_SIZE];
  logic [SEMID_WIDTH-1:0]  que_semid_d [QUE_SIZE];
`ifdef JELLY_RTOS_SEMAPHORE_ARRAY_PRIORITY_EN
  // Priority is only kept when it can influence wakeup selection.
  logic [TSKPRI_WIDTH-1:0] que_tskpri_q [QUE_SIZE];
  logic [TSKPRI_WIDTH-1:0] que_tskpri_d [QUE_SIZE];
  logic [TSKPRI_WIDTH-1:0] sig_pri;
`endif
  logic [QUECNT_WIDTH-1:0] quecnt_q, quecnt_d;

  logic                    wakeup_valid_q, wakeup_valid_d;
  logic [TSKID_WIDTH-1:0]  wakeup_tskid_q, wakeup_tskid_d;
  logic                    pol_ack_q, pol_ack_d;
  logic                    rel_ack_q, rel_ack_d;
  logic                    err_q, err_d;

  logic                    do_sig, do_pol, do_wai, do_rel, any_op;
  logic                    sem_ok;
  logic [SEMCNT_WIDTH-1:0] cur_cnt;
  logic                    sig_hit, rel_hit;
  logic [QIDX_WIDTH-1:0]   sig_idx, rel_idx;
  logic                    cnt_wr;
  logic [SEMCNT_WIDTH-1:0] cnt_new;
  logic                    rm_en, ins_en;
  logic [QIDX_WIDTH-1:0]   rm_idx;

  // Fixed-priority op selection; lower-priority requests are simply dropped.
  assign do_sig = bus.sig_sem_valid;
  assign do_pol = !bus.sig_sem_valid && bus.pol_sem_valid;
  assign do_wai = !bus.sig_sem_valid && !bus.pol_sem_valid && bus.wai_sem_valid;
  assign do_rel = !bus.sig_sem_valid && !bus.pol_sem_valid && !bus.wai_sem_valid
                  && bus.rel_wai_valid;
  assign any_op = do_sig || do_pol || do_wai || do_rel;
  assign sem_ok = int'(bus.op_semid) < SEM_NUM;

  // Read the addressed count (zero when the id is out of range).
  always_comb begin
    cur_cnt = '0;
    for (int i = 0; i < SEM_NUM; i++) begin
      if (int'(bus.op_semid) == i) cur_cnt = cnt_q[i];
    end
  end

  // Queue search: wakeup candidate for sig_sem and oldest match for rel_wai.
  always_comb begin
    sig_hit = 1'b0;
    sig_idx = '0;
    rel_hit = 1'b0;
    rel_idx = '0;
`ifdef JELLY_RTOS_SEMAPHORE_ARRAY_PRIORITY_EN
    sig_pri = '0;
`endif
    for (int i = 0; i < QUE_SIZE; i++) begin
      if (i < int'(quecnt_q) && que_semid_q[i] == bus.op_semid) begin
`ifdef JELLY_RTOS_SEMAPHORE_ARRAY_PRIORITY_EN
        // Strict less-than keeps the older entry on equal priority.
        if (!sig_hit || que_tskpri_q[i] < sig_pri) begin
          sig_hit = 1'b1;
          sig_idx = QIDX_WIDTH'(i);
          sig_pri = que_tskpri_q[i];
        end
`else
        if (!sig_hit) begin
          sig_hit = 1'b1;
          sig_idx = QIDX_WIDTH'(i);
        end
`endif
        if (!rel_hit && que_tskid_q[i] == bus.op_tskid) begin
          rel_hit = 1'b1;
          rel_idx = QIDX_WIDTH'(i);
        end
      end
    end
  end

  // Decide the effect of the selected op on counts, queue and responses.
  always_comb begin
    cnt_wr         = 1'b0;
    cnt_new        = cur_cnt;
    rm_en          = 1'b0;
    rm_idx         = '0;
    ins_en         = 1'b0;
    wakeup_valid_d = 1'b0;
    wakeup_tskid_d = '0;
    pol_ack_d      = 1'b0;
    rel_ack_d      = 1'b0;
    err_d          = 1'b0;
    if (any_op && !sem_ok) begin
      err_d = 1'b1;
    end else if (do_sig) begin
      if (sig_hit) begin
        rm_en          = 1'b1;
        rm_idx         = sig_idx;
        wakeup_valid_d = 1'b1;
        wakeup_tskid_d = que_tskid_q[sig_idx];
      end else if (int'(cur_cnt) < MAX_SEMCNT) begin
        cnt_wr  = 1'b1;
        cnt_new = cur_cnt + SEMCNT_WIDTH'(1);
      end else begin
        err_d = 1'b1;
      end
    end else if (do_pol) begin
      if (cur_cnt != '0) begin
        cnt_wr    = 1'b1;
        cnt_new   = cur_cnt - SEMCNT_WIDTH'(1);
        pol_ack_d = 1'b1;
      end
    end else if (do_wai) begin
      if (cur_cnt != '0) begin
        cnt_wr         = 1'b1;
        cnt_new        = cur_cnt - SEMCNT_WIDTH'(1);
        wakeup_valid_d = 1'b1;
        wakeup_tskid_d = bus.op_tskid;
      end else if (int'(quecnt_q) < QUE_SIZE) begin
        ins_en = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else if (do_rel) begin
      if (rel_hit) begin
        rm_en     = 1'b1;
        rm_idx    = rel_idx;
        rel_ack_d = 1'b1;
      end
    end
  end

  // Build next counts and next queue contents (shift-down on removal, append on insert).
  always_comb begin
    cnt_d       = cnt_q;
    que_tskid_d = que_tskid_q;
    que_semid_d = que_semid_q;
`ifdef JELLY_RTOS_SEMAPHORE_ARRAY_PRIORITY_EN
    que_tskpri_d = que_tskpri_q;
`endif
    quecnt_d    = quecnt_q;
    for (int i = 0; i < SEM_NUM; i++) begin
      if (cnt_wr && int'(bus.op_semid) == i) cnt_d[i] = cnt_new;
    end
    if (rm_en) begin
      for (int i = 0; i < QUE_SIZE - 1; i++) begin
        if (i >= int'(rm_idx)) begin
          que_tskid_d[i] = que_tskid_q[i+1];
          que_semid_d[i] = que_semid_q[i+1];
`ifdef JELLY_RTOS_SEMAPHORE_ARRAY_PRIORITY_EN
          que_tskpri_d[i] = que_tskpri_q[i+1];
`endif
        end
      end
      quecnt_d = quecnt_q - QUECNT_WIDTH'(1);
    end else if (ins_en) begin
      for (int i = 0; i < QUE_SIZE; i++) begin
        if (i == int'(quecnt_q)) begin
          que_tskid_d[i] = bus.op_tskid;
          que_semid_d[i] = bus.op_semid;
`ifdef JELLY_RTOS_SEMAPHORE_ARRAY_PRIORITY_EN
          que_tskpri_d[i] = bus.op_tskpri;
`endif
        end
      end
      quecnt_d = quecnt_q + QUECNT_WIDTH'(1);
    end
  end

  // State and registered responses; everything holds while cke is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SEM_NUM; i++) cnt_q[i] <= SEMCNT_WIDTH'(INIT_SEMCNT);
      for (int i = 0; i < QUE_SIZE; i++) begin
        que_tskid_q[i] <= '0;
        que_semid_q[i] <= '0;
`ifdef JELLY_RTOS_SEMAPHORE_ARRAY_PRIORITY_EN
        que_tskpri_q[i] <= '0;
`endif
      end
      quecnt_q       <= '0;
      wakeup_valid_q <= 1'b0;
      wakeup_tskid_q <= '0;
      pol_ack_q      <= 1'b0;
      rel_ack_q      <= 1'b0;
      err_q          <= 1'b0;
    end else if (cke) begin
      cnt_q          <= cnt_d;
      que_tskid_q    <= que_tskid_d;
      que_semid_q    <= que_semid_d;
`ifdef JELLY_RTOS_SEMAPHORE_ARRAY_PRIORITY_EN
      que_tskpri_q   <= que_tskpri_d;
`endif
      quecnt_q       <= quecnt_d;
      wakeup_valid_q <= wakeup_valid_d;
      wakeup_tskid_q <= wakeup_tskid_d;
      pol_ack_q      <= pol_ack_d;
      rel_ack_q      <= rel_ack_d;
      err_q          <= err_d;
    end
  end

  for (genvar g = 0; g < SEM_NUM; g++) begin : g_semcnt
    assign bus.semcnt[g*SEMCNT_WIDTH +: SEMCNT_WIDTH] = cnt_q[g];
  end

  assign bus.quecnt       = quecnt_q;
  assign bus.wakeup_valid = wakeup_valid_q;
  assign bus.wakeup_tskid = wakeup_tskid_q;
  assign bus.pol_sem_ack  = pol_ack_q;
  assign bus.rel_wai_ack  = rel_ack_q;
  assign bus.op_err       = err_q;

endmodule

// File: tb/tb_jelly_rtos_semaphore_array.sv
// Directed bench for jelly_rtos_semaphore_array.
// dut0: default parameters (SEM_NUM=4, INIT_SEMCNT=0).
// dut1: SEM_NUM=3, INIT_SEMCNT=2 (poll sequence and out-of-range id).
module tb_jelly_rtos_semaphore_array;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cke = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  jelly_rtos_semaphore_array_if #(.SEM_NUM(4)) bus0 ();
  jelly_rtos_semaphore_array_if #(.SEM_NUM(3)) bus1 ();

  jelly_rtos_semaphore_array dut0 (
    .reset (reset),
    .clk   (clk),
    .cke   (cke),
    .bus   (bus0.slave)
  );

  jelly_rtos_semaphore_array #(.SEM_NUM(3), .INIT_SEMCNT(2)) dut1 (
    .reset (reset),
    .clk   (clk),
    .cke   (cke),
    .bus   (bus1.slave)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic idle();
    bus0.sig_sem_valid = 1'b0; bus0.pol_sem_valid = 1'b0;
    bus0.wai_sem_valid = 1'b0; bus0.rel_wai_valid = 1'b0;
    bus1.sig_sem_valid = 1'b0; bus1.pol_sem_valid = 1'b0;
    bus1.wai_sem_valid = 1'b0; bus1.rel_wai_valid = 1'b0;
  endtask

  // Drive one op for one edge on dut0 (sel=0) or dut1 (sel=1); returns #1 after the edge.
  task automatic op(input int sel, input logic s, input logic p, input logic w,
                    input logic r, input int semid, input int tskid, input int tskpri);
    if (sel == 0) begin
      bus0.op_semid = 2'(semid); bus0.op_tskid = 4'(tskid); bus0.op_tskpri = 4'(tskpri);
      bus0.sig_sem_valid = s; bus0.pol_sem_valid = p;
      bus0.wai_sem_valid = w; bus0.rel_wai_valid = r;
    end else begin
      bus1.op_semid = 2'(semid); bus1.op_tskid = 4'(tskid); bus1.op_tskpri = 4'(tskpri);
      bus1.sig_sem_valid = s; bus1.pol_sem_valid = p;
      bus1.wai_sem_valid = w; bus1.rel_wai_valid = r;
    end
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic test_reset();
    n_tests++; if (bus0.semcnt !== 16'h0000) begin n_fail++; $display("FAIL reset_semcnt0: got %h expected 0000", bus0.semcnt); end
    n_tests++; if (bus1.semcnt !== 12'h222) begin n_fail++; $display("FAIL reset_semcnt1: got %h expected 222", bus1.semcnt); end
    n_tests++; if (bus0.quecnt !== 4'd0) begin n_fail++; $display("FAIL reset_quecnt: got %0d expected 0", bus0.quecnt); end
    n_tests++;
    if ({bus0.wakeup_valid, bus0.pol_sem_ack, bus0.rel_wai_ack, bus0.op_err, bus0.wakeup_tskid} !== 8'h00) begin
      n_fail++; $display("FAIL reset_outputs: got %b %b %b %b %0d expected all 0", bus0.wakeup_valid,
                         bus0.pol_sem_ack, bus0.rel_wai_ack, bus0.op_err, bus0.wakeup_tskid);
    end
  endtask

  task automatic test_poll();
    logic       exp_ack [3];
    logic [3:0] exp_cnt [3];
    exp_ack[0] = 1'b1; exp_ack[1] = 1'b1; exp_ack[2] = 1'b0;
    exp_cnt[0] = 4'd1; exp_cnt[1] = 4'd0; exp_cnt[2] = 4'd0;
    for (int i = 0; i < 3; i++) begin
      op(1, 0, 1, 0, 0, 1, 0, 0);
      n_tests++; if (bus1.pol_sem_ack !== exp_ack[i]) begin n_fail++; $display("FAIL poll_ack[%0d]: got %b expected %b", i, bus1.pol_sem_ack, exp_ack[i]); end
      n_tests++; if (bus1.semcnt[7:4] !== exp_cnt[i]) begin n_fail++; $display("FAIL poll_cnt[%0d]: got %0d expected %0d", i, bus1.semcnt[7:4], exp_cnt[i]); end
      n_tests++; if (bus1.op_err !== 1'b0) begin n_fail++; $display("FAIL poll_err[%0d]: got %b expected 0", i, bus1.op_err); end
    end
  endtask

  task automatic test_fifo();
    op(0, 0, 0, 1, 0, 0, 3, 0);
    n_tests++; if (bus0.quecnt !== 4'd1) begin n_fail++; $display("FAIL fifo_q1: got %0d expected 1", bus0.quecnt); end
    n_tests++; if (bus0.wakeup_valid !== 1'b0) begin n_fail++; $display("FAIL fifo_nowake: got %b expected 0", bus0.wakeup_valid); end
    op(0, 0, 0, 1, 0, 0, 5, 0);
    n_tests++; if (bus0.quecnt !== 4'd2) begin n_fail++; $display("FAIL fifo_q2: got %0d expected 2", bus0.quecnt); end
    op(0, 1, 0, 0, 0, 0, 0, 0);
    n_tests++; if (bus0.quecnt !== 4'd1) begin n_fail++; $display("FAIL fifo_q3: got %0d expected 1", bus0.quecnt); end
    n_tests++; if (bus0.wakeup_valid !== 1'b1 || bus0.wakeup_tskid !== 4'd3) begin
      n_fail++; $display("FAIL fifo_wake1: got v=%b id=%0d expected v=1 id=3", bus0.wakeup_valid, bus0.wakeup_tskid); end
    n_tests++; if (bus0.semcnt[3:0] !== 4'd0) begin n_fail++; $display("FAIL fifo_cnt: got %0d expected 0", bus0.semcnt[3:0]); end
    op(0, 1, 0, 0, 0, 0, 0, 0);
    n_tests++; if (bus0.wakeup_valid !== 1'b1 || bus0.wakeup_tskid !== 4'd5) begin
      n_fail++; $display("FAIL fifo_wake2: got v=%b id=%0d expected v=1 id=5", bus0.wakeup_valid, bus0.wakeup_tskid); end
    // Response is a single-cycle pulse.
    @(posedge clk); #1;
    n_tests++; if (bus0.wakeup_valid !== 1'b0) begin n_fail++; $display("FAIL fifo_pulse: got %b expected 0", bus0.wakeup_valid); end
  endtask

  task automatic test_priority();
    logic [3:0] exp_id [3];
`ifdef JELLY_RTOS_SEMAPHORE_ARRAY_PRIORITY_EN
    exp_id[0] = 4'd2; exp_id[1] = 4'd4; exp_id[2] = 4'd1;
`else
    exp_id[0] = 4'd1; exp_id[1] = 4'd2; exp_id[2] = 4'd4;
`endif
    op(0, 0, 0, 1, 0, 2, 1, 7);
    op(0, 0, 0, 1, 0, 2, 2, 2);
    op(0, 0, 0, 1, 0, 2, 4, 2);
    for (int i = 0; i < 3; i++) begin
      op(0, 1, 0, 0, 0, 2, 0, 0);
      n_tests++; if (bus0.wakeup_valid !== 1'b1 || bus0.wakeup_tskid !== exp_id[i]) begin
        n_fail++; $display("FAIL prio_wake[%0d]: got v=%b id=%0d expected v=1 id=%0d", i, bus0.wakeup_valid, bus0.wakeup_tskid, exp_id[i]); end
    end
    n_tests++; if (bus0.quecnt !== 4'd0) begin n_fail++; $display("FAIL prio_q: got %0d expected 0", bus0.quecnt); end
  endtask

  task automatic test_queue_full();
    logic [3:0] exp_s1 [3];
    exp_s1[0] = 4'd1; exp_s1[1] = 4'd5; exp_s1[2] = 4'd7;
    for (int i = 0; i < 8; i++) op(0, 0, 0, 1, 0, i % 2, i, 0);
    n_tests++; if (bus0.quecnt !== 4'd8) begin n_fail++; $display("FAIL full_q8: got %0d expected 8", bus0.quecnt); end
    op(0, 0, 0, 1, 0, 0, 9, 0);
    n_tests++; if (bus0.op_err !== 1'b1 || bus0.quecnt !== 4'd8) begin
      n_fail++; $display("FAIL full_err: got err=%b q=%0d expected err=1 q=8", bus0.op_err, bus0.quecnt); end
    op(0, 0, 0, 0, 1, 1, 3, 0);
    n_tests++; if (bus0.rel_wai_ack !== 1'b1 || bus0.quecnt !== 4'd7) begin
      n_fail++; $display("FAIL rel_hit: got ack=%b q=%0d expected ack=1 q=7", bus0.rel_wai_ack, bus0.quecnt); end
    op(0, 0, 0, 0, 1, 1, 3, 0);
    n_tests++; if (bus0.rel_wai_ack !== 1'b0 || bus0.op_err !== 1'b0 || bus0.quecnt !== 4'd7) begin
      n_fail++; $display("FAIL rel_miss: got ack=%b err=%b q=%0d expected ack=0 err=0 q=7", bus0.rel_wai_ack, bus0.op_err, bus0.quecnt); end
    for (int i = 0; i < 3; i++) begin
      op(0, 1, 0, 0, 0, 1, 0, 0);
      n_tests++; if (bus0.wakeup_valid !== 1'b1 || bus0.wakeup_tskid !== exp_s1[i]) begin
        n_fail++; $display("FAIL order_s1[%0d]: got v=%b id=%0d expected v=1 id=%0d", i, bus0.wakeup_valid, bus0.wakeup_tskid, exp_s1[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      op(0, 1, 0, 0, 0, 0, 0, 0);
      n_tests++; if (bus0.wakeup_valid !== 1'b1 || bus0.wakeup_tskid !== 4'(2 * i)) begin
        n_fail++; $display("FAIL order_s0[%0d]: got v=%b id=%0d expected v=1 id=%0d", i, bus0.wakeup_valid, bus0.wakeup_tskid, 2 * i); end
    end
    n_tests++; if (bus0.quecnt !== 4'd0) begin n_fail++; $display("FAIL drain_q: got %0d expected 0", bus0.quecnt); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 15; i++) op(0, 1, 0, 0, 0, 3, 0, 0);
    n_tests++; if (bus0.semcnt[15:12] !== 4'd15 || bus0.op_err !== 1'b0) begin
      n_fail++; $display("FAIL sat_fill: got cnt=%0d err=%b expected cnt=15 err=0", bus0.semcnt[15:12], bus0.op_err); end
    op(0, 1, 0, 0, 0, 3, 0, 0);
    n_tests++; if (bus0.semcnt[15:12] !== 4'd15 || bus0.op_err !== 1'b1) begin
      n_fail++; $display("FAIL sat_over: got cnt=%0d err=%b expected cnt=15 err=1", bus0.semcnt[15:12], bus0.op_err); end
    // wai on a non-zero count completes at once.
    op(0, 0, 0, 1, 0, 3, 6, 0);
    n_tests++; if (bus0.semcnt[15:12] !== 4'd14 || bus0.wakeup_valid !== 1'b1 || bus0.wakeup_tskid !== 4'd6) begin
      n_fail++; $display("FAIL wai_now: got cnt=%0d v=%b id=%0d expected cnt=14 v=1 id=6", bus0.semcnt[15:12], bus0.wakeup_valid, bus0.wakeup_tskid); end
    // dut1 counts after the poll test: sem0=2, sem1=0, sem2=2.
    op(1, 1, 0, 0, 0, 3, 0, 0);
    n_tests++; if (bus1.op_err !== 1'b1 || bus1.semcnt !== 12'h202) begin
      n_fail++; $display("FAIL badid_sig: got err=%b cnt=%h expected err=1 cnt=202", bus1.op_err, bus1.semcnt); end
    op(1, 0, 0, 1, 0, 3, 2, 0);
    n_tests++; if (bus1.op_err !== 1'b1 || bus1.quecnt !== 4'd0 || bus1.wakeup_valid !== 1'b0) begin
      n_fail++; $display("FAIL badid_wai: got err=%b q=%0d v=%b expected err=1 q=0 v=0", bus1.op_err, bus1.quecnt, bus1.wakeup_valid); end
  endtask

  task automatic test_cke();
    cke = 1'b0;
    op(0, 1, 0, 0, 0, 1, 0, 0);
    cke = 1'b1;
    n_tests++; if (bus0.semcnt[7:4] !== 4'd0) begin n_fail++; $display("FAIL cke_hold: got %0d expected 0", bus0.semcnt[7:4]); end
  endtask

  task automatic test_simultaneous_and_reset();
    op(0, 1, 0, 1, 0, 0, 7, 0);
    n_tests++; if (bus0.semcnt[3:0] !== 4'd1 || bus0.quecnt !== 4'd0 || bus0.wakeup_valid !== 1'b0) begin
      n_fail++; $display("FAIL simul: got cnt=%0d q=%0d v=%b expected cnt=1 q=0 v=0", bus0.semcnt[3:0], bus0.quecnt, bus0.wakeup_valid); end
    op(0, 0, 0, 1, 0, 1, 8, 0);
    op(0, 0, 0, 1, 0, 2, 9, 0);
    op(0, 0, 0, 1, 0, 0, 10, 0);  // completes immediately (sem0 count 1)
    n_tests++; if (bus0.quecnt !== 4'd2 || bus0.wakeup_valid !== 1'b1) begin
      n_fail++; $display("FAIL pre_reset: got q=%0d v=%b expected q=2 v=1", bus0.quecnt, bus0.wakeup_valid); end
    bus0.op_semid = 2'd1; bus0.sig_sem_valid = 1'b1;
    #2 reset = 1'b1;
    #1;
    n_tests++; if (bus0.quecnt !== 4'd0 || bus0.semcnt !== 16'h0000 || bus1.semcnt !== 12'h222) begin
      n_fail++; $display("FAIL midreset_state: got q=%0d cnt0=%h cnt1=%h expected q=0 cnt0=0000 cnt1=222", bus0.quecnt, bus0.semcnt, bus1.semcnt); end
    n_tests++; if (bus0.wakeup_valid !== 1'b0 || bus0.wakeup_tskid !== 4'd0) begin
      n_fail++; $display("FAIL midreset_out: got v=%b id=%0d expected v=0 id=0", bus0.wakeup_valid, bus0.wakeup_tskid); end
    idle();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    op(0, 1, 0, 0, 0, 1, 0, 0);
    n_tests++; if (bus0.semcnt[7:4] !== 4'd1 || bus0.quecnt !== 4'd0) begin
      n_fail++; $display("FAIL post_reset: got cnt=%0d q=%0d expected cnt=1 q=0", bus0.semcnt[7:4], bus0.quecnt); end
  endtask

  initial begin
    bus0.op_semid = '0; bus0.op_tskid = '0; bus0.op_tskpri = '0;
    bus1.op_semid = '0; bus1.op_tskid = '0; bus1.op_tskpri = '0;
    idle();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_poll();
    test_fifo();
    test_priority();
    test_queue_full();
    test_saturate();
    test_cke();
    test_simultaneous_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
